// File: rtl/ctr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctr_pkg : shared state encoding and scan-counter defaults  | rev 1.0
// ---------------------------------------------------------------------------
package ctr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam int DEFAULT_W       = 2;
  localparam int DEFAULT_MODULUS = 3;

endpackage
`default_nettype wire

// File: rtl/sat_ctr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_ctr : event counter that either saturates or wraps  | rev 1.0
// ---------------------------------------------------------------------------
module sat_ctr #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic at_max;
  assign at_max = &count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !(SATURATE && at_max)) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctr_seq_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctr_seq_monitor : locks onto a mod-N counter stream, flags breaks  | rev 1.0
// ---------------------------------------------------------------------------
module ctr_seq_monitor
  import ctr_pkg::*;
#(
  parameter int W       = DEFAULT_W,
  parameter int MODULUS = DEFAULT_MODULUS,
  parameter int LOCK_N  = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     value,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  localparam int           GW      = $clog2(LOCK_N + 1);
  localparam logic [W:0]   MOD_EXT = (W + 1)'(MODULUS);
  localparam logic [W-1:0] LAST    = W'(MODULUS - 1);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_N);

  mon_state_t    state, state_n;
  logic [W-1:0]  expected, expected_n;
  logic [GW-1:0] good, good_n;
  logic          err_n, wrap_n;

  logic          range_ok, match;
  logic [W-1:0]  next_val;
  logic [GW-1:0] good_inc;

  assign range_ok = ({1'b0, value} < MOD_EXT);
  assign match    = range_ok && (value == expected);
  assign next_val = (value == LAST) ? '0 : value + 1'b1;
  assign good_inc = good + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      expected   <= '0;
      good       <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      expected   <= expected_n;
      good       <= good_n;
      err_pulse  <= err_n;
      wrap_pulse <= wrap_n;
    end
  end

  always_comb begin
    state_n    = state;
    expected_n = expected;
    good_n     = good;
    err_n      = 1'b0;
    wrap_n     = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (range_ok) begin
            state_n    = ACQ;
            expected_n = next_val;
            good_n     = '0;
          end
        end
        ACQ: begin
          if (match) begin
            good_n     = good_inc;
            expected_n = next_val;
            if (good_inc == LOCK_G) state_n = LOCKED;
          end else if (range_ok) begin
            expected_n = next_val;
            good_n     = '0;
          end else begin
            state_n = HUNT;
          end
        end
        LOCKED: begin
          if (match) begin
            expected_n = next_val;
            // A correct arrival at 0 means the previous sample was MODULUS-1.
            wrap_n     = (value == '0);
          end else begin
            err_n  = 1'b1;
            good_n = '0;
            if (range_ok) begin
              state_n    = ACQ;
              expected_n = next_val;
            end else begin
              state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  sat_ctr #(.WIDTH(CNT_W), .SATURATE(1'b1)) u_err_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_n),
    .count (err_count)
  );

  sat_ctr #(.WIDTH(CNT_W), .SATURATE(1'b0)) u_wrap_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrap_n),
    .count (wrap_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_ctr_seq_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ctr_seq_monitor : directed + random checks against a sequence model  | rev 1.0
// ---------------------------------------------------------------------------
module tb_ctr_seq_monitor;

  localparam int M     = 3;
  localparam int LN    = 2;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    value;
  logic          locked, err_pulse, wrap_pulse;
  logic [CW-1:0] err_count, wrap_count;

  int checks = 0;
  int errors = 0;

  // Model: mode 0=hunting, 1=acquiring, 2=locked
  int m_mode, m_exp, m_good, m_ec, m_wc;
  bit m_pe, m_pw;

  ctr_seq_monitor #(.W(2), .MODULUS(M), .LOCK_N(LN), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_good = 0; m_ec = 0; m_wc = 0; m_pe = 0; m_pw = 0;
  endtask

  task automatic model_sample(input bit e, input int v);
    bit in_rng, hit;
    m_pe = 0; m_pw = 0;
    if (!e) return;
    in_rng = (v < M);
    hit    = in_rng && (v == m_exp);
    if (m_mode == 0) begin
      if (in_rng) begin m_mode = 1; m_exp = (v + 1) % M; m_good = 0; end
    end else if (m_mode == 1) begin
      if (hit) begin
        m_good++; m_exp = (v + 1) % M;
        if (m_good == LN) m_mode = 2;
      end else if (in_rng) begin
        m_exp = (v + 1) % M; m_good = 0;
      end else m_mode = 0;
    end else begin
      if (hit) begin
        m_exp = (v + 1) % M;
        if (v == 0) begin m_pw = 1; m_wc = (m_wc + 1) % CMAX; end
      end else begin
        m_pe = 1;
        if (m_ec < CMAX - 1) m_ec++;
        if (in_rng) begin m_mode = 1; m_exp = (v + 1) % M; m_good = 0; end
        else m_mode = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".locked"},     32'(locked),     32'(m_mode == 2));
    check_eq({tag, ".err_pulse"},  32'(err_pulse),  32'(m_pe));
    check_eq({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(m_pw));
    check_eq({tag, ".err_count"},  32'(err_count),  32'(m_ec));
    check_eq({tag, ".wrap_count"}, 32'(wrap_count), 32'(m_wc));
  endtask

  task automatic step(input string tag, input bit e, input int v);
    en = e; value = 2'(v);
    @(posedge clk);
    model_sample(e, v);
    #1;
    check_all(tag);
  endtask

  initial begin
    int cur;
    model_reset();
    rst = 1'b1; en = 1'b0; value = 2'd0;
    #1;
    check_all("reset");
    @(posedge clk); #3;
    rst = 1'b0;

    // Acquire and lock, then three more periods of wraps
    for (int i = 0; i < 12; i++) step("lock_seq", 1'b1, i % M);
    // Stall error then relock
    step("stall", 1'b1, 0); step("stall", 1'b1, 1); step("stall", 1'b1, 1);
    step("relock", 1'b1, 2); step("relock", 1'b1, 0); step("relock", 1'b1, 1);
    // Out-of-range while locked
    step("oor", 1'b1, 3);
    step("oor_relock", 1'b1, 0); step("oor_relock", 1'b1, 1); step("oor_relock", 1'b1, 2);
    // en=0 gap with junk values
    for (int i = 0; i < 5; i++) step("en_gap", 1'b0, int'($urandom_range(0, 3)));
    step("resume", 1'b1, 0); step("resume", 1'b1, 1);
    // Saturate err_count with errors separated by relocks
    for (int k = 0; k < 5; k++) begin
      step("sat_err", 1'b1, 1);
      step("sat_relock", 1'b1, 2); step("sat_relock", 1'b1, 0); step("sat_relock", 1'b1, 1);
    end
    // Five wraps to roll wrap_count over
    for (int i = 0; i < 15; i++) step("wrap_roll", 1'b1, (i + 2) % M);

    // Async reset mid-acquisition with good=1
    step("pre_rst", 1'b1, 3);
    step("pre_rst", 1'b1, 0);
    step("pre_rst", 1'b1, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    step("post_rst", 1'b1, 1);
    step("post_rst", 1'b1, 2);
    step("post_rst", 1'b1, 0);

    // Random stimulus following a mostly-correct source counter
    cur = 1;
    for (int i = 0; i < 400; i++) begin
      int r, v;
      bit e;
      e = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 15));
      if (r == 0)      v = 3;
      else if (r <= 2) v = int'($urandom_range(0, 2));
      else             v = cur;
      if (e && v < M) cur = (v + 1) % M;
      step("random", e, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctr_seq_monitor.md
Name: ctr_seq_monitor

Overview:
- Consumer-side checker for the modulo-N digit/scan counter stream produced by our small free-running counters. The default is the 2-bit mod-3 counter.
- Samples the counter value on qualified cycles and acquires lock on the expected sequence 0,1,…,N-1,0.
- Flags sequence breaks and counts wraps and errors.
- Sits beside the display-scan logic as a self-check and debug block. Its outputs go to LEDs or the top-level status.

Parameters:
- W, 2, width of the monitored counter value
- MODULUS, 3, counter period; legal values are 0..MODULUS-1 (2 ≤ MODULUS ≤ 2^W)
- LOCK_N, 2, consecutive correct transitions required to enter LOCKED (≥1)
- CNT_W, 8, width of wrap_count and err_count

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  sample qualifier; value is examined only when en=1
- value  input  W  counter value under observation
- locked  output  1  high while in LOCKED state
- err_pulse  output  1  one-cycle pulse on a detected sequence error while LOCKED
- wrap_pulse  output  1  one-cycle pulse on a correct MODULUS-1→0 transition while LOCKED
- err_count  output  CNT_W  saturating count of err_pulse events
- wrap_count  output  CNT_W  wrapping count of wrap_pulse events

Behaviour:
- Reset (async, any time, including mid-acquisition):
  - state=HUNT; locked=0, err_pulse=0, wrap_pulse=0, err_count=0, wrap_count=0
  - internal expected=0, good=0
- All outputs are registered. Responses appear the cycle after the sampled en=1 edge (latency 1).
- With en=0: state, expected, good and counters hold; err_pulse and wrap_pulse are 0.
- Definitions:
  - range_ok = (value < MODULUS)
  - match = range_ok and value == expected
  - next(v) = (v == MODULUS-1) ? 0 : v+1
- HUNT:
  - en and range_ok → ACQ; expected=next(value); good=0
  - en and !range_ok → stay in HUNT
- ACQ:
  - en and match → good+1; expected=next(value); if good+1 == LOCK_N → LOCKED
  - en and range_ok and !match → reseed: expected=next(value), good=0, stay in ACQ
  - en and !range_ok → HUNT
  - No error is counted in HUNT or ACQ.
- LOCKED:
  - en and match → expected=next(value). If value==0 (i.e. the previous value was MODULUS-1), wrap_pulse=1 and wrap_count+1 (mod 2^CNT_W).
  - en and !match (wrong value or out of range):
    - err_pulse=1; err_count+1, saturating at 2^CNT_W-1
    - locked=0 from the next cycle
    - if range_ok → ACQ seeded with that value (good=0); otherwise → HUNT
- Any mismatch while LOCKED is one error, including a repeated value (stall) and a skipped value.
- err_pulse and wrap_pulse are mutually exclusive by construction.
- locked is asserted on the cycle after the LOCK_N-th good transition.
- A wrap on that same transition does not pulse: wrap_pulse requires LOCKED when the sample is taken.
- Counter boundaries:
  - err_count holds at all-ones.
  - wrap_count rolls over from all-ones to 0 with no flag.

Decomposition:
- Shared package ctr_pkg holds:
  - the state encoding constants (HUNT=2'd0, ACQ=2'd1, LOCKED=2'd2)
  - the default MODULUS/W pair matching the scan counter
- One natural sub-module: sat_ctr (CNT_W-bit incrementer with a saturate/wrap select parameter), instantiated twice for err_count and wrap_count.
- The FSM and comparator stay in the top module.

Test Plan:
- Reset, then en=1 with value 0,1,2,0,1,2,… (defaults) → locked=1 one cycle after the 3rd sample (2 good transitions). wrap_pulse on the sample 0 following the first locked 2. wrap_count=3 after three further cycles of 0,1,2.
- While locked, drive 0,1,1 → err_pulse one cycle after the second 1; err_count=1; locked=0. Continue 2,0 → locked=1 again after 2 good transitions, with no second error.
- While locked, drive value=3 (out of range) → err_pulse=1 and state HUNT. Next 0,1,2 → locked=1 after the 2 is sampled.
- Toggle en=0 for 5 cycles mid-sequence with value changing arbitrarily → no pulses and counts unchanged. Resume en=1 with the correct next value → stays locked.
- CNT_W=2: inject 5 errors (relock between them) → err_count stops at 3. Drive 5 wraps → wrap_count sequence 1,2,3,0,1.
- Assert rst asynchronously between clock edges while in ACQ with good=1 → all outputs 0 immediately. After release, the first in-range sample only seeds; no lock on the next cycle.
